// File: rtl/usb_uart_pkg.sv
// Shared definitions for the buffered USB CDC-UART bridge.
package usb_uart_pkg;

    // USB full-speed core clock.
    localparam int USB_CLK_HZ = 48_000_000;

    // 2.5 us of SE0 at the core clock marks a host-driven bus reset.
    localparam int SE0_CYCLES_DEFAULT = USB_CLK_HZ / 400_000;

    // TX unpacker: IDLE waits for a word, SEND streams its bytes LSB first.
    typedef enum logic [0:0] {
        TX_IDLE = 1'b0,
        TX_SEND = 1'b1
    } tx_state_e;

    // Width in bits of a user word made of word_bytes byte lanes.
    function automatic int lane_bits(input int word_bytes);
        return 8 * word_bytes;
    endfunction

    // Width of a byte-lane index; never narrower than one bit.
    function automatic int lane_idx_bits(input int word_bytes);
        return (word_bytes > 1) ? $clog2(word_bytes) : 1;
    endfunction

endpackage

// File: rtl/usb_uart_core.sv
// Behavioural stand-in for the USB CDC-UART core so the bridge elaborates on its own:
// it keeps the pins idle and loops every byte offered on uart_in straight back out on
// uart_out, with uart_in_ready following uart_out_ready.
module usb_uart_core (
    input  logic        clk_48mhz,
    input  logic        reset,
    output logic        usb_p_tx,
    output logic        usb_n_tx,
    input  logic        usb_p_rx,
    input  logic        usb_n_rx,
    output logic        usb_tx_en,
    input  logic [7:0]  uart_in_data,
    input  logic        uart_in_valid,
    output logic        uart_in_ready,
    output logic [7:0]  uart_out_data,
    output logic        uart_out_valid,
    input  logic        uart_out_ready,
    output logic [11:0] debug
);

    assign usb_p_tx       = 1'b1;
    assign usb_n_tx       = 1'b0;
    assign usb_tx_en      = 1'b0;
    assign uart_out_data  = uart_in_data;
    assign uart_out_valid = uart_in_valid && !reset;
    assign uart_in_ready  = uart_out_ready && !reset;

    // Snapshot of line state and byte handshake for the debug bus.
    always_ff @(posedge clk_48mhz or posedge reset) begin
        if (reset) begin
            debug <= 12'h000;
        end else begin
            debug <= {usb_p_rx, usb_n_rx, uart_in_valid, uart_out_ready, uart_in_data};
        end
    end

endmodule

// File: rtl/usb_uart_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers, synchronous flush and fill level.
module usb_uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     wr_en,
    output logic                     full,
    output logic [WIDTH-1:0]         rd_data,
    input  logic                     rd_en,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic             wr_ok_s;
    logic             rd_ok_s;

    // Full when the wrap bits differ and the addresses match.
    assign full    = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign empty   = (wr_ptr_r == rd_ptr_r);
    assign level   = wr_ptr_r - rd_ptr_r;
    assign rd_data = mem_r[rd_ptr_r[AW-1:0]];

    // Writes into a full FIFO and reads from an empty one are refused.
    assign wr_ok_s = wr_en && !full && !flush;
    assign rd_ok_s = rd_en && !empty && !flush;

    // Pointer update; flush empties the FIFO in one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else if (flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (wr_ok_s) wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
            if (rd_ok_s) rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
        end
    end

    // Storage array; contents need no reset since the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (wr_ok_s) mem_r[wr_ptr_r[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/usb_uart_fifo_bridge.sv
// Word-wide buffered USB CDC-UART bridge: pin tristate, TX/RX FIFOs, byte unpacker and
// packer, selectable RX full policy and an SE0 bus-reset detector that flushes everything.
module usb_uart_fifo_bridge
    import usb_uart_pkg::*;
#(
    parameter int WORD_BYTES   = 1,
    parameter int TX_DEPTH     = 16,
    parameter int RX_DEPTH     = 16,
    parameter int RX_DROP_FULL = 0,
    parameter int SE0_CYCLES   = SE0_CYCLES_DEFAULT
) (
    input  logic                          clk_48mhz,
    input  logic                          reset,
    inout  wire                           pin_usb_p,
    inout  wire                           pin_usb_n,
    input  logic [8*WORD_BYTES-1:0]       tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic [8*WORD_BYTES-1:0]       rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [$clog2(TX_DEPTH):0]     tx_level,
    output logic [$clog2(RX_DEPTH):0]     rx_level,
    output logic                          rx_overflow,
    input  logic                          rx_ovf_clr,
    output logic                          usb_bus_reset,
    output logic [11:0]                   debug
);

    localparam int                W        = lane_bits(WORD_BYTES);
    localparam int                IW       = lane_idx_bits(WORD_BYTES);
    localparam int                SW       = $clog2(SE0_CYCLES + 1);
    localparam logic [IW-1:0]     LAST_IDX = IW'(WORD_BYTES - 1);
    localparam logic [IW-1:0]     IDX_ONE  = IW'(1);
    localparam logic [SW-1:0]     SE0_MAX  = SW'(SE0_CYCLES);
    localparam logic [SW-1:0]     SE0_PRE  = SW'(SE0_CYCLES - 1);

    logic          core_reset_s;
    logic          usb_p_tx_s, usb_n_tx_s, usb_tx_en_s, usb_p_rx_s, usb_n_rx_s;
    logic [7:0]    uart_in_data_s, uart_out_data_s;
    logic          uart_in_valid_s, uart_in_ready_s, uart_out_valid_s, uart_out_ready_s;
    logic          se0_s;
    logic [SW-1:0] se0_cnt_r;
    logic          bus_reset_r;
    logic          tx_full_s, tx_empty_s, tx_pop_s;
    logic [W-1:0]  tx_fifo_data_s, tx_shreg_r;
    logic [IW-1:0] tx_idx_r;
    tx_state_e     tx_state_r, tx_state_nxt_s;
    logic          rx_full_s, rx_empty_s, rx_accept_s, rx_last_s, rx_push_s, rx_drop_s;
    logic [W-1:0]  rx_word_r, rx_word_s;
    logic [IW-1:0] rx_idx_r;
    logic          rx_ovf_r;

    // Pins follow the core while it transmits; otherwise the core sees the line.
    assign core_reset_s = !reset;
    assign pin_usb_p    = usb_tx_en_s ? usb_p_tx_s : 1'bz;
    assign pin_usb_n    = usb_tx_en_s ? usb_n_tx_s : 1'bz;
    assign usb_p_rx_s   = usb_tx_en_s ? 1'b1 : pin_usb_p;
    assign usb_n_rx_s   = usb_tx_en_s ? 1'b0 : pin_usb_n;

    usb_uart_core u_core (
        .clk_48mhz      (clk_48mhz),
        .reset          (core_reset_s),
        .usb_p_tx       (usb_p_tx_s),
        .usb_n_tx       (usb_n_tx_s),
        .usb_p_rx       (usb_p_rx_s),
        .usb_n_rx       (usb_n_rx_s),
        .usb_tx_en      (usb_tx_en_s),
        .uart_in_data   (uart_in_data_s),
        .uart_in_valid  (uart_in_valid_s),
        .uart_in_ready  (uart_in_ready_s),
        .uart_out_data  (uart_out_data_s),
        .uart_out_valid (uart_out_valid_s),
        .uart_out_ready (uart_out_ready_s),
        .debug          (debug)
    );

    // SE0 run-length counter (saturating) and one-shot bus-reset pulse.
    assign se0_s = !usb_tx_en_s && !pin_usb_p && !pin_usb_n;
    always_ff @(posedge clk_48mhz or negedge reset) begin
        if (!reset) begin
            se0_cnt_r   <= '0;
            bus_reset_r <= 1'b0;
        end else begin
            if (!se0_s)                  se0_cnt_r <= '0;
            else if (se0_cnt_r != SE0_MAX) se0_cnt_r <= se0_cnt_r + {{(SW-1){1'b0}}, 1'b1};
            bus_reset_r <= se0_s && (se0_cnt_r == SE0_PRE);
        end
    end
    assign usb_bus_reset = bus_reset_r;

    usb_uart_sync_fifo #(.WIDTH(W), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk     (clk_48mhz),
        .rst_n   (reset),
        .flush   (bus_reset_r),
        .wr_data (tx_data),
        .wr_en   (tx_valid),
        .full    (tx_full_s),
        .rd_data (tx_fifo_data_s),
        .rd_en   (tx_pop_s),
        .empty   (tx_empty_s),
        .level   (tx_level)
    );
    assign tx_ready = !tx_full_s;

    // Unpacker next state: pop a word in IDLE, stream bytes in SEND; bus reset aborts.
    always_comb begin
        tx_state_nxt_s  = tx_state_r;
        tx_pop_s        = 1'b0;
        uart_in_valid_s = 1'b0;
        if (bus_reset_r) begin
            tx_state_nxt_s = TX_IDLE;
        end else begin
            case (tx_state_r)
                TX_IDLE: begin
                    if (!tx_empty_s) begin
                        tx_pop_s       = 1'b1;
                        tx_state_nxt_s = TX_SEND;
                    end else begin
                        tx_state_nxt_s = TX_IDLE;
                    end
                end
                TX_SEND: begin
                    uart_in_valid_s = 1'b1;
                    if (uart_in_ready_s && (tx_idx_r == LAST_IDX)) tx_state_nxt_s = TX_IDLE;
                    else                                          tx_state_nxt_s = TX_SEND;
                end
                default: tx_state_nxt_s = TX_IDLE;
            endcase
        end
    end
    assign uart_in_data_s = tx_shreg_r[7:0];

    // Unpacker state register plus byte shift register and lane index.
    always_ff @(posedge clk_48mhz or negedge reset) begin
        if (!reset) begin
            tx_state_r <= TX_IDLE;
            tx_shreg_r <= '0;
            tx_idx_r   <= '0;
        end else begin
            tx_state_r <= tx_state_nxt_s;
            if (bus_reset_r) begin
                tx_shreg_r <= '0;
                tx_idx_r   <= '0;
            end else if (tx_pop_s) begin
                tx_shreg_r <= tx_fifo_data_s;
                tx_idx_r   <= '0;
            end else if (uart_in_valid_s && uart_in_ready_s) begin
                tx_shreg_r <= tx_shreg_r >> 4'd8;
                tx_idx_r   <= (tx_idx_r == LAST_IDX) ? '0 : tx_idx_r + IDX_ONE;
            end
        end
    end

    // Packer: the incoming byte lands in the lane selected by the index.
    assign rx_last_s        = (rx_idx_r == LAST_IDX);
    assign uart_out_ready_s = (RX_DROP_FULL != 0) ? 1'b1 : !(rx_full_s && rx_last_s);
    assign rx_accept_s      = uart_out_valid_s && uart_out_ready_s;
    assign rx_push_s        = rx_accept_s && rx_last_s && !bus_reset_r;
    assign rx_drop_s        = rx_push_s && rx_full_s && (RX_DROP_FULL != 0);

    // Word being assembled with the current byte merged in.
    always_comb begin
        rx_word_s = rx_word_r;
        rx_word_s[{rx_idx_r, 3'b000} +: 8] = uart_out_data_s;
    end

    // Packer lane index and partial word; a completed or dropped word restarts at lane 0.
    always_ff @(posedge clk_48mhz or negedge reset) begin
        if (!reset) begin
            rx_idx_r  <= '0;
            rx_word_r <= '0;
        end else if (bus_reset_r) begin
            rx_idx_r  <= '0;
            rx_word_r <= '0;
        end else if (rx_accept_s) begin
            if (rx_last_s) begin
                rx_idx_r  <= '0;
                rx_word_r <= '0;
            end else begin
                rx_idx_r  <= rx_idx_r + IDX_ONE;
                rx_word_r <= rx_word_s;
            end
        end
    end

    usb_uart_sync_fifo #(.WIDTH(W), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk     (clk_48mhz),
        .rst_n   (reset),
        .flush   (bus_reset_r),
        .wr_data (rx_word_s),
        .wr_en   (rx_push_s),
        .full    (rx_full_s),
        .rd_data (rx_data),
        .rd_en   (rx_ready),
        .empty   (rx_empty_s),
        .level   (rx_level)
    );
    assign rx_valid = !rx_empty_s;

    // Sticky overflow flag; a new drop wins over a simultaneous clear.
    always_ff @(posedge clk_48mhz or negedge reset) begin
        if (!reset)          rx_ovf_r <= 1'b0;
        else if (rx_drop_s)  rx_ovf_r <= 1'b1;
        else if (rx_ovf_clr) rx_ovf_r <= 1'b0;
    end
    assign rx_overflow = rx_ovf_r;

endmodule
